// File: rtl/spi_dep_cdc_handshake_tx_pkg.sv
// Shared types and defaults for the 4-phase CDC handshake transmitter.
package spi_dep_cdc_handshake_tx_pkg;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } tx_state_e;

    // Counter width able to hold TIMEOUT_CYC-1; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
        return (timeout_cyc > 1) ? $clog2(timeout_cyc) : 1;
    endfunction

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by reset.
module cdc_sync_2ff (
    input  logic clk_i,
    input  logic async_nreset_i,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_i or negedge async_nreset_i) begin
        if (!async_nreset_i) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_dep_cdc_handshake_tx.sv
// Source-side 4-phase request/acknowledge transmitter with a request timeout
// and a sticky error flag.
module spi_dep_cdc_handshake_tx
    import spi_dep_cdc_handshake_tx_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk_i,
    input  logic              async_nreset_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              req_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ack_i,
    output logic              done_o,
    output logic              err_o,
    input  logic              err_clr_i
);

    localparam int unsigned      CNT_W      = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYC != 0);

    tx_state_e         state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              via_ack, via_ack_next;
    logic              req_next, done_next, err_next;
    logic [DATA_W-1:0] data_next;
    logic              ack_sync;

    cdc_sync_2ff u_ack_sync (
        .clk_i          (clk_i),
        .async_nreset_i (async_nreset_i),
        .d              (ack_i),
        .q              (ack_sync)
    );

    assign ready_o = (state == IDLE);

    // Next-state and next-output decode.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        via_ack_next = via_ack;
        req_next     = req_o;
        data_next    = data_o;
        done_next    = 1'b0;
        err_next     = err_o;

        if (err_clr_i) begin
            err_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (valid_i) begin
                    data_next  = data_i;
                    req_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_W'(1);
                end
                // Acknowledge wins over a timeout landing on the same edge.
                if (ack_sync) begin
                    req_next     = 1'b0;
                    via_ack_next = 1'b1;
                    state_next   = DROP;
                end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
                    req_next     = 1'b0;
                    err_next     = 1'b1;
                    via_ack_next = 1'b0;
                    state_next   = DROP;
                end
            end
            DROP: begin
                if (!ack_sync) begin
                    done_next  = via_ack;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge async_nreset_i) begin
        if (!async_nreset_i) begin
            state   <= IDLE;
            cnt     <= '0;
            via_ack <= 1'b0;
            req_o   <= 1'b0;
            data_o  <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            via_ack <= via_ack_next;
            req_o   <= req_next;
            data_o  <= data_next;
            done_o  <= done_next;
            err_o   <= err_next;
        end
    end

endmodule

// File: doc/spi_dep_cdc_handshake_tx.md
SPI_DEP_CDC_HANDSHAKE_TX -- requirements
Module: spi_dep_cdc_handshake_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the transferred word.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: clk_i cycles allowed in REQ before abort; 0 disables the timeout.
REQ-003 SHALL have port clk_i, input, 1: source-domain clock.
REQ-004 SHALL have port async_nreset_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i, input, 1: source word available.
REQ-006 SHALL have port data_i, input, DATA_W: source word.
REQ-007 SHALL have port ready_o, output, 1: block accepts a word this cycle.
REQ-008 SHALL have port req_o, output, 1: 4-phase request to the remote domain.
REQ-009 SHALL have port data_o, output, DATA_W: held word; stable whenever req_o=1.
REQ-010 SHALL have port ack_i, input, 1: asynchronous acknowledge from the remote domain.
REQ-011 SHALL have port done_o, output, 1: one-cycle pulse on normal completion.
REQ-012 SHALL have port err_o, output, 1: sticky timeout flag.
REQ-013 SHALL have port err_clr_i, input, 1: clears err_o.

Function
REQ-014 SHALL pass ack_i through a 2-flop synchronizer reset to 0; FSM uses only ack_sync.
REQ-015 SHALL implement states IDLE, REQ, DROP; ready_o = (state==IDLE), combinational from state only.
REQ-016 IDLE: on valid_i&ready_o at edge k, SHALL register data_o<=data_i, req_o<=1, clear timeout counter, enter REQ at edge k.
REQ-017 REQ: when ack_sync=1, SHALL deassert req_o and enter DROP on the same edge; with ack_i rising before edge m, req_o falls at edge m+2.
REQ-018 REQ: when the counter reaches TIMEOUT_CYC-1 with ack_sync=0, SHALL deassert req_o, set err_o, enter DROP.
REQ-019 Simultaneous ack_sync=1 and timeout SHALL be treated as normal completion: no err_o.
REQ-020 DROP: when ack_sync=0, SHALL enter IDLE; done_o SHALL pulse for one cycle on that edge only if DROP was entered via ack.
REQ-021 data_o SHALL change only on accept; it holds its value in DROP and IDLE.
REQ-022 The counter SHALL saturate, never wrap, and count only in REQ.
REQ-023 err_clr_i SHALL clear err_o next edge; a same-cycle timeout SHALL take priority over clear (err_o stays 1).
REQ-024 valid_i while not ready_o SHALL be ignored; no data loss is signalled, as the source must hold valid_i until ready_o.
REQ-025 An ack_i pulse outside REQ or DROP SHALL have no effect other than synchronizer activity.

Reset
REQ-026 Asserting async_nreset_i SHALL immediately force state=IDLE, req_o=0, data_o=0, done_o=0, err_o=0, counter=0, and both synchronizer flops=0.
REQ-027 Reset mid-transfer SHALL abort without done_o or err_o; after release the block SHALL enter IDLE with ready_o=1 one cycle after release.
REQ-028 Deassertion of async_nreset_i SHALL be delivered synchronously to clk_i by the existing reset synchronizer upstream; this block is not required to re-synchronize it.

Structure
REQ-029 A shared package SHALL hold the state enum typedef (IDLE, REQ, DROP) and the default DATA_W and TIMEOUT_CYC constants.
REQ-030 The 2-flop synchronizer SHALL be a sub-module named cdc_sync_2ff (parameterless, 1 bit, async active-low reset).
REQ-031 All other logic SHALL be in one always_ff FSM/datapath process plus combinational output decode.

Verification
REQ-032 Normal transfer: data_i=8'hA5, valid_i at edge 0, ack_i raised 5 cycles after req_o and dropped 3 cycles after req_o falls -> data_o=8'hA5 while req_o=1, req_o falls 2 edges after ack_i sampled, done_o pulses once, ready_o returns to 1.
REQ-033 Back-to-back: words 8'h01, 8'h02 with continuous valid_i -> second accepted only after return to IDLE; data_o never changes during req_o=1.
REQ-034 Timeout: TIMEOUT_CYC=16, ack_i held 0 -> req_o falls after 16 REQ cycles, err_o=1, no done_o; err_clr_i pulse -> err_o=0.
REQ-035 Late ack after timeout: ack_i high in DROP -> block stays in DROP (ready_o=0) until ack_i low plus 2 cycles, then IDLE without done_o.
REQ-036 Reset mid-REQ: assert async_nreset_i between clock edges -> req_o=0, data_o=0 with no clock edge required; ready_o=1 one cycle after release.
REQ-037 Tie: ack_sync rises on the timeout cycle (TIMEOUT_CYC=8) -> done_o pulses, err_o stays 0.
